// File: rtl/cpu_parameters.sv
// Core-wide sizing shared by the register file and its scoreboard.
package cpu_parameters;
  localparam int xlen      = 32;
  localparam int reg_count = 32;
  localparam int reg_idx_w = $clog2(reg_count);
endpackage

// File: rtl/register_manager_if.sv
// Decode / write-back bundle for the register manager.
//
// Handshake: decode raises issue_req with rs1/rs2/issue_rd/issue_rd_v and
// holds all of them stable until issue_ok is seen high; the instruction is
// transferred at the rising edge where issue_req and issue_ok are both 1.
// issue_ok is combinational, and never asserted under flush or reset.
// result_v has no back-pressure: when high, result/rd are consumed at the
// next rising edge, and rd is never 0.
interface register_manager_if;
  import cpu_parameters::*;

  logic [xlen-1:0]      result;
  logic [reg_idx_w-1:0] rd;
  logic                 result_v;
  logic                 issue_req;
  logic [reg_idx_w-1:0] rs1;
  logic [reg_idx_w-1:0] rs2;
  logic [reg_idx_w-1:0] issue_rd;
  logic                 issue_rd_v;
  logic                 flush;
  logic                 issue_ok;
  logic [xlen-1:0]      rs1_data;
  logic [xlen-1:0]      rs2_data;

  modport master (
    output result, rd, result_v, issue_req, rs1, rs2, issue_rd, issue_rd_v, flush,
    input  issue_ok, rs1_data, rs2_data
  );

  modport slave (
    input  result, rd, result_v, issue_req, rs1, rs2, issue_rd, issue_rd_v, flush,
    output issue_ok, rs1_data, rs2_data
  );
endinterface

// File: rtl/register_scoreboard.sv
// Busy-bit scoreboard: one bit per architectural register marking a pending
// write-back, plus the operand and destination readiness lookups.
module register_scoreboard
  import cpu_parameters::*;
#(
  parameter bit BYPASS = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 set_en,
  input  logic [reg_idx_w-1:0] set_idx,
  input  logic                 clr_en,
  input  logic [reg_idx_w-1:0] clr_idx,
  input  logic                 flush,
  input  logic [reg_idx_w-1:0] rs1,
  input  logic [reg_idx_w-1:0] rs2,
  input  logic [reg_idx_w-1:0] wr_idx,
  input  logic                 wr_v,
  output logic                 rs1_ready,
  output logic                 rs2_ready,
  output logic                 wr_ready
);

  logic [reg_count-1:0] busy;
  logic [reg_count-1:0] busy_next;

  // Next busy vector: clear on write-back, then set on issue so a same-cycle
  // set wins; flush drops every pending bit; x0 is never busy.
  always_comb begin
    busy_next = busy;
    if (clr_en) busy_next[clr_idx] = 1'b0;
    if (set_en) busy_next[set_idx] = 1'b1;
    if (flush)  busy_next = '0;
    busy_next[0] = 1'b0;
  end

  // Busy register, cleared asynchronously so reset discards pending writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

  // Sources may use a same-cycle write-back only when it is forwarded;
  // the destination only needs the old writer to have completed.
  assign rs1_ready = !busy[rs1] || (BYPASS && clr_en && (clr_idx == rs1));
  assign rs2_ready = !busy[rs2] || (BYPASS && clr_en && (clr_idx == rs2));
  assign wr_ready  = !wr_v || (wr_idx == '0) || !busy[wr_idx] ||
                     (clr_en && (clr_idx == wr_idx));

endmodule

// File: rtl/register_manager.sv
// Integer register file x1..x31 with a busy scoreboard gating operand issue.
module register_manager
  import cpu_parameters::*;
#(
  parameter bit BYPASS = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  register_manager_if.slave   bus
);

  logic [xlen-1:0] regs [1:reg_count-1];
  logic [xlen-1:0] rs1_stored;
  logic [xlen-1:0] rs2_stored;
  logic            wb_en;
  logic            rs1_ready;
  logic            rs2_ready;
  logic            wr_ready;
  logic            set_en;
  logic            issue_ok;

  assign wb_en = bus.result_v && (bus.rd != '0);

  // Register array: async clear, write-back lands one edge after result_v.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < reg_count; i++) regs[i] <= '0;
    end else if (wb_en) begin
      for (int i = 1; i < reg_count; i++)
        if (bus.rd == reg_idx_w'(i)) regs[i] <= bus.result;
    end
  end

  // Stored-value read muxes; x0 has no storage and falls through as 0.
  always_comb begin
    rs1_stored = '0;
    rs2_stored = '0;
    for (int i = 1; i < reg_count; i++) begin
      if (bus.rs1 == reg_idx_w'(i)) rs1_stored = regs[i];
      if (bus.rs2 == reg_idx_w'(i)) rs2_stored = regs[i];
    end
  end

  // Operand outputs with optional write-back forwarding; forced to 0 in
  // reset so a write-back on the bus cannot leak through the bypass.
  always_comb begin
    bus.rs1_data = rs1_stored;
    bus.rs2_data = rs2_stored;
    if (BYPASS && wb_en && (bus.rd == bus.rs1)) bus.rs1_data = bus.result;
    if (BYPASS && wb_en && (bus.rd == bus.rs2)) bus.rs2_data = bus.result;
    if (!rst_n || (bus.rs1 == '0)) bus.rs1_data = '0;
    if (!rst_n || (bus.rs2 == '0)) bus.rs2_data = '0;
  end

  register_scoreboard #(
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en    (set_en),
    .set_idx   (bus.issue_rd),
    .clr_en    (wb_en),
    .clr_idx   (bus.rd),
    .flush     (bus.flush),
    .rs1       (bus.rs1),
    .rs2       (bus.rs2),
    .wr_idx    (bus.issue_rd),
    .wr_v      (bus.issue_rd_v),
    .rs1_ready (rs1_ready),
    .rs2_ready (rs2_ready),
    .wr_ready  (wr_ready)
  );

  assign issue_ok = rst_n && bus.issue_req && !bus.flush &&
                    rs1_ready && rs2_ready && wr_ready;
  assign set_en   = issue_ok && bus.issue_rd_v && (bus.issue_rd != '0);
  assign bus.issue_ok = issue_ok;

endmodule

// File: tb/tb_register_manager.sv
// Bench for register_manager: directed vector table, reset sequences and
// randomized traffic against a reference model, on BYPASS=1 and BYPASS=0.
module tb_register_manager;
  import cpu_parameters::*;

  typedef struct {
    logic            rv;
    logic [4:0]      rd;
    logic [xlen-1:0] res;
    logic            req;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      ird;
    logic            ird_v;
    logic            flush;
  } in_t;

  typedef struct {
    in_t             i;
    logic            ok;
    logic [xlen-1:0] d1;
    logic [xlen-1:0] d2;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  register_manager_if bus1 ();
  register_manager_if bus0 ();

  register_manager #(.BYPASS(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  register_manager #(.BYPASS(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));

  // Clock/reset block.
  always #5 clk = ~clk;

  // Reference model: architectural values and pending-writer flags per DUT
  // (index 1 = forwarding variant, index 0 = no forwarding).
  logic [xlen-1:0] m_regs [2][32];
  bit              m_busy [2][32];
  in_t             cur;

  function automatic logic [xlen-1:0] m_data(int m, logic [4:0] rs);
    if (!rst_n || rs == 5'd0) return '0;
    if (m == 1 && cur.rv && cur.rd == rs) return cur.res;
    return m_regs[m][rs];
  endfunction

  function automatic bit m_ok(int m);
    bit r1, r2, w;
    r1 = !m_busy[m][cur.rs1] || (m == 1 && cur.rv && cur.rd == cur.rs1);
    r2 = !m_busy[m][cur.rs2] || (m == 1 && cur.rv && cur.rd == cur.rs2);
    w  = !cur.ird_v || cur.ird == 5'd0 || !m_busy[m][cur.ird] || (cur.rv && cur.rd == cur.ird);
    return rst_n && cur.req && !cur.flush && r1 && r2 && w;
  endfunction

  task automatic model_edge();
    bit ok [2];
    if (!rst_n) return;
    for (int m = 0; m < 2; m++) ok[m] = m_ok(m);
    for (int m = 0; m < 2; m++) begin
      if (cur.rv && cur.rd != 5'd0) m_regs[m][cur.rd] = cur.res;
      if (cur.flush) begin
        for (int r = 0; r < 32; r++) m_busy[m][r] = 1'b0;
      end else begin
        if (cur.rv) m_busy[m][cur.rd] = 1'b0;
        if (ok[m] && cur.ird_v && cur.ird != 5'd0) m_busy[m][cur.ird] = 1'b1;
      end
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++)
      for (int r = 0; r < 32; r++) begin
        m_regs[m][r] = '0;
        m_busy[m][r] = 1'b0;
      end
  endtask

  // Driver: same stimulus into both DUTs.
  task automatic apply(input in_t v);
    cur = v;
    bus1.result = v.res;  bus1.rd = v.rd;   bus1.result_v = v.rv;
    bus1.issue_req = v.req; bus1.rs1 = v.rs1; bus1.rs2 = v.rs2;
    bus1.issue_rd = v.ird; bus1.issue_rd_v = v.ird_v; bus1.flush = v.flush;
    bus0.result = v.res;  bus0.rd = v.rd;   bus0.result_v = v.rv;
    bus0.issue_req = v.req; bus0.rs1 = v.rs1; bus0.rs2 = v.rs2;
    bus0.issue_rd = v.ird; bus0.issue_rd_v = v.ird_v; bus0.flush = v.flush;
  endtask

  function automatic in_t mk_in(logic rv, logic [4:0] rd, logic [xlen-1:0] res, logic req,
                                logic [4:0] rs1, logic [4:0] rs2, logic [4:0] ird,
                                logic ird_v, logic flush);
    in_t v;
    v.rv = rv; v.rd = rd; v.res = res; v.req = req; v.rs1 = rs1; v.rs2 = rs2;
    v.ird = ird; v.ird_v = ird_v; v.flush = flush;
    return v;
  endfunction

  function automatic vec_t mk(in_t i, logic ok, logic [xlen-1:0] d1, logic [xlen-1:0] d2);
    vec_t v;
    v.i = i; v.ok = ok; v.d1 = d1; v.d2 = d2;
    return v;
  endfunction

  // Scoreboard compare.
  task automatic check(string name, logic [xlen-1:0] act, logic [xlen-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_model(string tag);
    check({tag, " ok_byp"},  xlen'(bus1.issue_ok), xlen'(m_ok(1)));
    check({tag, " rs1_byp"}, bus1.rs1_data, m_data(1, cur.rs1));
    check({tag, " rs2_byp"}, bus1.rs2_data, m_data(1, cur.rs2));
    check({tag, " ok_nob"},  xlen'(bus0.issue_ok), xlen'(m_ok(0)));
    check({tag, " rs1_nob"}, bus0.rs1_data, m_data(0, cur.rs1));
    check({tag, " rs2_nob"}, bus0.rs2_data, m_data(0, cur.rs2));
  endtask

  // One cycle: drive after the falling edge, compare, then commit the edge.
  task automatic step_vec(string tag, input vec_t v);
    @(negedge clk);
    apply(v.i);
    #1;
    check({tag, " ok"},  xlen'(bus1.issue_ok), xlen'(v.ok));
    check({tag, " rs1"}, bus1.rs1_data, v.d1);
    check({tag, " rs2"}, bus1.rs2_data, v.d2);
    check_model(tag);
    @(posedge clk);
    model_edge();
  endtask

  vec_t tbl [$];
  in_t  idle;
  in_t  rnd;

  initial begin
    model_reset();
    idle = mk_in(0, 0, '0, 0, 0, 0, 0, 0, 0);

    // Reset state: request and a forwardable write-back held during reset.
    apply(mk_in(1, 5'd1, 32'hDEAD_BEEF, 1, 5'd1, 5'd1, 5'd2, 1, 0));
    #1;
    check("reset ok",  xlen'(bus1.issue_ok), '0);
    check("reset rs1", bus1.rs1_data, '0);
    check("reset rs2", bus1.rs2_data, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    apply(idle);
    rst_n = 1'b1;

    // Directed vectors (forwarding variant expectations).
    tbl.push_back(mk(mk_in(1, 5'd5, 32'h1234, 0, 0, 0, 0, 0, 0), 0, 0, 0));
    tbl.push_back(mk(mk_in(0, 0, '0, 1, 5'd5, 0, 0, 0, 0), 1, 32'h1234, 0));
    tbl.push_back(mk(mk_in(0, 0, '0, 1, 0, 0, 5'd7, 1, 0), 1, 0, 0));
    tbl.push_back(mk(mk_in(0, 0, '0, 1, 0, 5'd7, 0, 0, 0), 0, 0, 0));
    tbl.push_back(mk(mk_in(1, 5'd7, 32'hAA, 1, 0, 5'd7, 0, 0, 0), 1, 0, 32'hAA));
    tbl.push_back(mk(mk_in(0, 0, '0, 1, 0, 0, 0, 0, 0), 1, 0, 0));
    tbl.push_back(mk(mk_in(1, 5'd9, 32'h99, 1, 0, 0, 5'd9, 1, 0), 1, 0, 0));
    tbl.push_back(mk(mk_in(0, 0, '0, 1, 5'd9, 0, 0, 0, 0), 0, 32'h99, 0));
    tbl.push_back(mk(mk_in(0, 0, '0, 1, 0, 0, 5'd3, 1, 0), 1, 0, 0));
    tbl.push_back(mk(mk_in(0, 0, '0, 1, 0, 0, 5'd4, 1, 0), 1, 0, 0));
    tbl.push_back(mk(mk_in(0, 0, '0, 1, 0, 0, 0, 0, 1), 0, 0, 0));
    tbl.push_back(mk(mk_in(0, 0, '0, 1, 5'd3, 5'd4, 0, 0, 0), 1, 0, 0));
    tbl.push_back(mk(mk_in(0, 0, '0, 1, 5'd9, 0, 0, 0, 0), 1, 32'h99, 0));
    tbl.push_back(mk(mk_in(0, 0, '0, 1, 0, 0, 5'd12, 1, 0), 1, 0, 0));
    tbl.push_back(mk(mk_in(0, 0, '0, 1, 0, 0, 5'd12, 1, 0), 0, 0, 0));
    tbl.push_back(mk(mk_in(1, 5'd12, 32'h55, 1, 0, 0, 5'd12, 1, 0), 1, 0, 0));
    tbl.push_back(mk(mk_in(0, 0, '0, 1, 5'd12, 0, 0, 0, 0), 0, 32'h55, 0));
    tbl.push_back(mk(mk_in(0, 0, '0, 0, 0, 0, 0, 0, 1), 0, 0, 0));
    tbl.push_back(mk(mk_in(0, 0, '0, 1, 5'd12, 0, 0, 0, 0), 1, 32'h55, 0));
    for (int n = 0; n < tbl.size(); n++) step_vec($sformatf("vec%0d", n), tbl[n]);

    // Reset between edges with x10 busy and written.
    step_vec("x10_set", mk(mk_in(1, 5'd10, 32'h77, 1, 0, 0, 5'd10, 1, 0), 1, 0, 0));
    @(negedge clk);
    apply(mk_in(1, 5'd10, 32'h33, 1, 5'd10, 5'd10, 0, 0, 0));
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst ok_byp",  xlen'(bus1.issue_ok), '0);
    check("midrst rs1_byp", bus1.rs1_data, '0);
    check("midrst ok_nob",  xlen'(bus0.issue_ok), '0);
    check("midrst rs2_nob", bus0.rs2_data, '0);
    @(posedge clk);
    @(negedge clk);
    apply(idle);
    rst_n = 1'b1;
    step_vec("post_rst", mk(mk_in(0, 0, '0, 1, 5'd10, 0, 0, 0, 0), 1, 0, 0));
    step_vec("post_wb",  mk(mk_in(1, 5'd10, 32'h42, 0, 0, 0, 0, 0, 0), 0, 0, 0));
    step_vec("post_rd",  mk(mk_in(0, 0, '0, 1, 5'd10, 5'd10, 0, 0, 0), 1, 32'h42, 32'h42));

    // Randomized traffic on a small register window to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rnd.rv    = ($urandom_range(0, 2) == 0);
      rnd.rd    = 5'($urandom_range(1, 7));
      rnd.res   = $urandom;
      rnd.req   = ($urandom_range(0, 3) != 0);
      rnd.rs1   = 5'($urandom_range(0, 7));
      rnd.rs2   = 5'($urandom_range(0, 7));
      rnd.ird   = 5'($urandom_range(0, 7));
      rnd.ird_v = ($urandom_range(0, 1) == 1);
      rnd.flush = ($urandom_range(0, 15) == 0);
      apply(rnd);
      #1;
      check_model($sformatf("rnd%0d", n));
      @(posedge clk);
      model_edge();
    end

    @(negedge clk);
    apply(idle);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_manager.md
REGISTER_MANAGER -- requirements
Module: register_manager

Interface
REQ-001 SHALL have parameter: BYPASS, default 1, 1 = same-cycle write-back forwarded to read ports, 0 = no forwarding.
REQ-002 SHALL use xlen from cpu_parameters for all data widths.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 result  in  xlen  write-back data.
REQ-006 rd  in  5  write-back destination register.
REQ-007 result_v  in  1  write-back valid; rd is never 0 when valid.
REQ-008 issue_req  in  1  decode requests operands for one instruction.
REQ-009 rs1  in  5  source register 1 index.
REQ-010 rs2  in  5  source register 2 index.
REQ-011 issue_rd  in  5  destination of issuing instruction.
REQ-012 issue_rd_v  in  1  issuing instruction writes issue_rd.
REQ-013 flush  in  1  pipeline flush on exception.
REQ-014 issue_ok  out  1  operands valid, instruction accepted this cycle.
REQ-015 rs1_data  out  xlen  value of rs1.
REQ-016 rs2_data  out  xlen  value of rs2.

Function
REQ-017 SHALL hold 31 xlen-bit registers x1..x31; x0 reads 0 always, never stored.
REQ-018 result_v=1 and rd!=0 SHALL write result into rd at the next edge (1-cycle write latency).
REQ-019 SHALL keep a 32-bit busy scoreboard; busy[0] permanently 0.
REQ-020 result_v=1 SHALL clear busy[rd] at the next edge.
REQ-021 issue_ok=1 with issue_rd_v=1 and issue_rd!=0 SHALL set busy[issue_rd] at the next edge.
REQ-022 Set and clear of the same register in one cycle: set wins (busy stays 1, register data still written).
REQ-023 rsN_data SHALL be combinational: 0 if rsN=0; result if BYPASS=1, result_v=1, rd=rsN; else stored value.
REQ-024 rsN is ready when busy[rsN]=0, or BYPASS=1 and result_v=1 with rd=rsN.
REQ-025 WAW guard: issue_rd is ready when issue_rd_v=0, issue_rd=0, busy[issue_rd]=0, or result_v=1 with rd=issue_rd.
REQ-026 issue_ok = issue_req and not flush and rs1, rs2, issue_rd ready; combinational, no latency.
REQ-027 issue_ok=0 SHALL change no scoreboard bit; decode holds the request (stall) until granted.
REQ-028 flush=1 SHALL clear all busy bits at the next edge; a write-back in the same cycle is still written to the register file.
REQ-029 Back-to-back issues to the same rd SHALL stall the second until the first write-back is seen.

Reset
REQ-030 rst_n=0 SHALL immediately clear all registers and busy bits, independent of clk.
REQ-031 During reset issue_ok SHALL be 0 and rsN_data SHALL read 0.
REQ-032 Reset mid-operation SHALL discard pending busy bits; write-backs arriving after reset release write normally.

Structure
REQ-033 xlen and the register count (32) SHALL come from cpu_parameters; no new package types needed.
REQ-034 One sub-module SHALL be natural: register_scoreboard (busy vector, set/clear/flush, ready lookups); register array stays in register_manager.

Verification
REQ-035 Write x5=0x1234 via result_v; next cycle issue_req rs1=5 -> issue_ok=1, rs1_data=0x1234.
REQ-036 Issue with issue_rd=7 accepted; next cycle rs2=7 -> issue_ok=0 until result_v rd=7 result=0xAA, that cycle issue_ok=1 and rs2_data=0xAA (BYPASS=1).
REQ-037 Write rd=0 attempt suppressed upstream; rs1=0 -> rs1_data=0, issue_ok=1 regardless.
REQ-038 Same cycle: result_v rd=9 and accepted issue issue_rd=9 -> next cycle busy[9]=1, x9 holds new result.
REQ-039 Busy x3,x4 then flush=1 -> next cycle rs1=3, rs2=4 grant issue_ok=1; issue_req with flush=1 -> issue_ok=0.
REQ-040 Assert rst_n=0 between edges with x10 busy and written -> outputs 0 immediately; after release rs1=10 -> issue_ok=1, rs1_data=0.
